cluster_event_core_buffer: RTL and testbench

- Per-core event buffer and sleep controller. Sits directly downstream of the cluster event map: one instance per core, fed by that core's 32-bit mapped event vector.
- Latches one-cycle event pulses into a sticky buffer and filters them through a software mask.
- Runs the core's wait-for-event handshake: drains the core, gates its clock, and wakes it on the first masked event.
- Exposes a saturating sleep-cycle counter for performance monitoring.

---
 rtl/cluster_event_core_buffer.sv | 120 ++++++++++++
 tb/tb_cluster_event_core_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_event_core_buffer.sv
// Per-core event buffer and wait-for-event sleep controller.
// Sticky event capture, software mask, core drain/clock-gate/wake handshake, sleep-cycle counter.
module cluster_event_core_buffer #(
   parameter logic [31:0] MASK_RST    = 32'h0000_0000,
   parameter int          SLEEP_CNT_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [31:0]            events_i,
   input  logic                   mask_we_i,
   input  logic [31:0]            mask_wdata_i,
   input  logic                   buf_clr_i,
   input  logic [31:0]            buf_clr_bits_i,
   input  logic                   wait_req_i,
   input  logic                   wait_clr_i,
   input  logic                   core_busy_i,
   output logic [31:0]            evt_mask_o,
   output logic [31:0]            evt_buffer_o,
   output logic [31:0]            evt_masked_o,
   output logic                   core_clk_en_o,
   output logic                   wait_ack_o,
   output logic                   sleeping_o,
   output logic [SLEEP_CNT_W-1:0] sleep_cnt_o
);

   // state  | meaning
   // ACTIVE | core running, accepts wait requests
   // DRAIN  | wait accepted, waiting for core pipeline to go idle
   // SLEEP  | core clock gated, waiting for a masked event
   // WAKE   | clock re-enabled, ack issued on exit
   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SLEEP  = 2'd2,
      ST_WAKE   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mask_q;
   logic [31:0] buf_q;
   logic [31:0] buf_d;
   logic [31:0] clr_vec;
   logic        clr_lat_q, clr_lat_d;
   logic        ack_q, ack_d;
   logic        clk_en_q;
   logic        pending;
   logic [SLEEP_CNT_W-1:0] cnt_q;

   // pending looks through the buffer so a same-cycle event counts
   assign pending = |((buf_q | events_i) & mask_q);

   always_comb begin
      clr_vec = buf_clr_i ? buf_clr_bits_i : 32'h0;
      if (ack_q && clr_lat_q)
         clr_vec = clr_vec | mask_q;
      buf_d = (buf_q & ~clr_vec) | events_i;
   end

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      clr_lat_d = clr_lat_q;
      case (state_q)
         ST_ACTIVE: begin
            if (wait_req_i) begin
               clr_lat_d = wait_clr_i;
               if (pending) ack_d   = 1'b1;
               else         state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pending)           state_d = ST_WAKE;
            else if (!core_busy_i) state_d = ST_SLEEP;
         end
         ST_SLEEP: begin
            if (pending) state_d = ST_WAKE;
         end
         ST_WAKE: begin
            state_d = ST_ACTIVE;
            ack_d   = 1'b1;
         end
         default: state_d = ST_ACTIVE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_ACTIVE;
         mask_q    <= MASK_RST;
         buf_q     <= 32'h0;
         clr_lat_q <= 1'b0;
         ack_q     <= 1'b0;
         clk_en_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         clr_lat_q <= clr_lat_d;
         ack_q     <= ack_d;
         // dedicated flop keeps the gate enable free of decode glitches
         clk_en_q  <= (state_d != ST_SLEEP);
         if (mask_we_i) mask_q <= mask_wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else if (state_q == ST_SLEEP && cnt_q != {SLEEP_CNT_W{1'b1}})
         cnt_q <= cnt_q + SLEEP_CNT_W'(1);
   end

   assign evt_mask_o    = mask_q;
   assign evt_buffer_o  = buf_q;
   assign evt_masked_o  = buf_q & mask_q;
   assign core_clk_en_o = clk_en_q;
   assign wait_ack_o    = ack_q;
   assign sleeping_o    = (state_q == ST_SLEEP);
   assign sleep_cnt_o   = cnt_q;

endmodule

// File: tb/tb_cluster_event_core_buffer.sv
// Self-checking bench for cluster_event_core_buffer: vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_cluster_event_core_buffer;
   localparam int CW = 8;

   logic          clk, rst;
   logic [31:0]   events, mask_wdata, clr_bits;
   logic          mask_we, buf_clr, wait_req, wait_clr, core_busy;
   logic [31:0]   evt_mask, evt_buffer, evt_masked;
   logic          clk_en, wait_ack, sleeping;
   logic [CW-1:0] sleep_cnt;

   int total = 0;
   int bad   = 0;

   cluster_event_core_buffer #(.MASK_RST(32'h0), .SLEEP_CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .events_i(events),
      .mask_we_i(mask_we), .mask_wdata_i(mask_wdata),
      .buf_clr_i(buf_clr), .buf_clr_bits_i(clr_bits),
      .wait_req_i(wait_req), .wait_clr_i(wait_clr), .core_busy_i(core_busy),
      .evt_mask_o(evt_mask), .evt_buffer_o(evt_buffer), .evt_masked_o(evt_masked),
      .core_clk_en_o(clk_en), .wait_ack_o(wait_ack), .sleeping_o(sleeping),
      .sleep_cnt_o(sleep_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ev;
      logic        we;
      logic [31:0] wd;
      logic        clr;
      logic [31:0] cb;
      logic        req;
      logic        wclr;
      logic        busy;
      logic [31:0] e_mask;
      logic [31:0] e_buf;
      logic        e_clk;
      logic        e_ack;
      logic        e_slp;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      events = 0; mask_we = 0; mask_wdata = 0; buf_clr = 0; clr_bits = 0;
      wait_req = 0; wait_clr = 0; core_busy = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   function automatic vec_t mk(logic [31:0] ev, logic we, logic [31:0] wd, logic clr,
                               logic [31:0] cb, logic req, logic wclr, logic busy,
                               logic [31:0] em, logic [31:0] eb, logic ec, logic ea,
                               logic es, logic [7:0] en);
      vec_t v;
      v.ev = ev; v.we = we; v.wd = wd; v.clr = clr; v.cb = cb; v.req = req;
      v.wclr = wclr; v.busy = busy; v.e_mask = em; v.e_buf = eb; v.e_clk = ec;
      v.e_ack = ea; v.e_slp = es; v.e_cnt = en;
      return v;
   endfunction

   // behavioural model state
   logic [31:0] m_buf, m_mask;
   bit          m_in_wait, m_asleep, m_waking, m_ack, m_clr_flag;
   int          m_cnt;

   task automatic model_reset();
      m_buf = 0; m_mask = 0; m_in_wait = 0; m_asleep = 0; m_waking = 0;
      m_ack = 0; m_clr_flag = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit          pend, nack;
      logic [31:0] clr;
      pend = |((m_buf | events) & m_mask);
      clr  = (buf_clr ? clr_bits : 32'h0) | ((m_ack && m_clr_flag) ? m_mask : 32'h0);
      nack = m_waking || (!m_in_wait && req_ok() && pend);
      if (m_asleep && m_cnt < (1 << CW) - 1) m_cnt++;
      m_buf = (m_buf & ~clr) | events;
      if (m_waking) begin
         m_waking = 0;
      end else if (m_in_wait) begin
         if (pend) begin
            m_in_wait = 0; m_asleep = 0; m_waking = 1;
         end else if (!m_asleep && !core_busy) begin
            m_asleep = 1;
         end
      end else if (wait_req) begin
         m_clr_flag = wait_clr;
         if (!pend) m_in_wait = 1;
      end
      if (mask_we) m_mask = mask_wdata;
      m_ack = nack;
   endtask

   function automatic bit req_ok();
      return wait_req && !m_waking;
   endfunction

   task automatic model_compare();
      chk("rnd_mask",   evt_mask,   m_mask);
      chk("rnd_buf",    evt_buffer, m_buf);
      chk("rnd_masked", evt_masked, m_buf & m_mask);
      chk("rnd_clk_en", {31'b0, clk_en},   {31'b0, !m_asleep});
      chk("rnd_ack",    {31'b0, wait_ack}, {31'b0, m_ack});
      chk("rnd_sleep",  {31'b0, sleeping}, {31'b0, m_asleep});
      chk("rnd_cnt",    {24'b0, sleep_cnt}, m_cnt[31:0]);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #23;
      chk("rst_async_clk_en", {31'b0, clk_en}, 32'h1);
      rst = 1'b0;
      cyc();
      chk("rst_mask",   evt_mask, 32'h0);
      chk("rst_buf",    evt_buffer, 32'h0);
      chk("rst_clk_en", {31'b0, clk_en}, 32'h1);
      chk("rst_cnt",    {24'b0, sleep_cnt}, 32'h0);
      chk("rst_ack",    {31'b0, wait_ack}, 32'h0);

      //            ev      we  wd       clr cb     req wclr busy  mask     buf      clk ack slp cnt
      vecs[0]  = mk(32'h0,   1, 32'h100, 0, 32'h0,  0,  0,  0,  32'h100, 32'h0,   1,  0,  0,  0);
      vecs[1]  = mk(32'h300, 0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h100, 32'h300, 1,  0,  0,  0);
      vecs[2]  = mk(32'h0,   0, 32'h0,   0, 32'h0,  1,  1,  0,  32'h100, 32'h300, 1,  1,  0,  0);
      vecs[3]  = mk(32'h0,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h100, 32'h200, 1,  0,  0,  0);
      vecs[4]  = mk(32'hFE,  0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h100, 32'h2FE, 1,  0,  0,  0);
      vecs[5]  = mk(32'h1,   0, 32'h0,   1, 32'hFF, 0,  0,  0,  32'h100, 32'h201, 1,  0,  0,  0);
      vecs[6]  = mk(32'h0,   1, 32'h1,   1, 32'hFFFF_FFFF, 0, 0, 0, 32'h1, 32'h0, 1,  0,  0,  0);
      vecs[7]  = mk(32'h0,   0, 32'h0,   0, 32'h0,  1,  0,  0,  32'h1,   32'h0,   1,  0,  0,  0);
      vecs[8]  = mk(32'h0,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h0,   0,  0,  1,  0);
      vecs[9]  = mk(32'h4,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h4,   0,  0,  1,  1);
      vecs[10] = mk(32'h0,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h4,   0,  0,  1,  2);
      vecs[11] = mk(32'h1,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h5,   1,  0,  0,  3);
      vecs[12] = mk(32'h0,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h5,   1,  1,  0,  3);
      vecs[13] = mk(32'h0,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h5,   1,  0,  0,  3);
      vecs[14] = mk(32'h0,   0, 32'h0,   1, 32'hF,  0,  0,  0,  32'h1,   32'h0,   1,  0,  0,  3);
      vecs[15] = mk(32'h0,   0, 32'h0,   0, 32'h0,  1,  1,  1,  32'h1,   32'h0,   1,  0,  0,  3);
      vecs[16] = mk(32'h1,   0, 32'h0,   0, 32'h0,  0,  0,  1,  32'h1,   32'h1,   1,  0,  0,  3);
      vecs[17] = mk(32'h0,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h1,   1,  1,  0,  3);
      vecs[18] = mk(32'h1,   0, 32'h0,   0, 32'h0,  0,  0,  0,  32'h1,   32'h1,   1,  0,  0,  3);
      vecs[19] = mk(32'h0,   0, 32'h0,   1, 32'hFFFF_FFFF, 0, 0, 0, 32'h1, 32'h0, 1,  0,  0,  3);

      for (int i = 0; i < 20; i++) begin
         events = vecs[i].ev; mask_we = vecs[i].we; mask_wdata = vecs[i].wd;
         buf_clr = vecs[i].clr; clr_bits = vecs[i].cb; wait_req = vecs[i].req;
         wait_clr = vecs[i].wclr; core_busy = vecs[i].busy;
         cyc();
         chk($sformatf("vec%0d_mask", i), evt_mask, vecs[i].e_mask);
         chk($sformatf("vec%0d_buf", i), evt_buffer, vecs[i].e_buf);
         chk($sformatf("vec%0d_masked", i), evt_masked, vecs[i].e_buf & vecs[i].e_mask);
         chk($sformatf("vec%0d_clk_en", i), {31'b0, clk_en}, {31'b0, vecs[i].e_clk});
         chk($sformatf("vec%0d_ack", i), {31'b0, wait_ack}, {31'b0, vecs[i].e_ack});
         chk($sformatf("vec%0d_sleep", i), {31'b0, sleeping}, {31'b0, vecs[i].e_slp});
         chk($sformatf("vec%0d_cnt", i), {24'b0, sleep_cnt}, {24'b0, vecs[i].e_cnt});
      end

      // drain under busy, ten gated cycles, wake on bit 16
      do_reset();
      mask_we = 1; mask_wdata = 32'h0001_0000;
      cyc();
      mask_we = 0; wait_req = 1; core_busy = 1;
      cyc();
      wait_req = 0;
      for (int i = 0; i < 3; i++) begin
         chk("drain_clk_en", {31'b0, clk_en}, 32'h1);
         chk("drain_sleep", {31'b0, sleeping}, 32'h0);
         cyc();
      end
      core_busy = 0;
      chk("drain_last_clk_en", {31'b0, clk_en}, 32'h1);
      cyc();
      chk("sleep_entry_clk_en", {31'b0, clk_en}, 32'h0);
      for (int i = 0; i < 9; i++) cyc();
      chk("sleep_clk_en", {31'b0, clk_en}, 32'h0);
      chk("sleep_cnt9", {24'b0, sleep_cnt}, 32'd9);
      events = 32'h0001_0000;
      cyc();
      events = 0;
      chk("wake_clk_en", {31'b0, clk_en}, 32'h1);
      chk("wake_no_ack", {31'b0, wait_ack}, 32'h0);
      cyc();
      chk("wake_ack", {31'b0, wait_ack}, 32'h1);
      chk("wake_cnt10", {24'b0, sleep_cnt}, 32'd10);
      cyc();
      chk("wake_ack_pulse", {31'b0, wait_ack}, 32'h0);

      // reset while asleep
      mask_we = 1; mask_wdata = 32'h1;
      cyc();
      mask_we = 0; wait_req = 1;
      cyc();
      wait_req = 0;
      cyc(); cyc(); cyc();
      chk("pre_rst_sleep", {31'b0, sleeping}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_clk_en", {31'b0, clk_en}, 32'h1);
      chk("mid_rst_cnt", {24'b0, sleep_cnt}, 32'h0);
      chk("mid_rst_sleep", {31'b0, sleeping}, 32'h0);
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_no_ack", {31'b0, wait_ack}, 32'h0);
      end
      mask_we = 1; mask_wdata = 32'h1;
      cyc();
      mask_we = 0; wait_req = 1;
      cyc();
      wait_req = 0;
      cyc();
      chk("post_rst_sleep", {31'b0, sleeping}, 32'h1);
      // long sleep saturates the counter
      for (int i = 0; i < 300; i++) cyc();
      chk("sat_cnt", {24'b0, sleep_cnt}, 32'd255);
      chk("sat_still_asleep", {31'b0, clk_en}, 32'h0);
      events = 32'h1;
      cyc();
      events = 0;
      cyc();
      chk("post_rst_ack", {31'b0, wait_ack}, 32'h1);
      chk("sat_cnt_hold", {24'b0, sleep_cnt}, 32'd255);

      // randomized traffic vs model
      do_reset();
      model_reset();
      model_compare();
      for (int i = 0; i < 4000; i++) begin
         events     = ($urandom_range(0, 9) == 0) ? (32'h1 << $urandom_range(0, 9)) : 32'h0;
         mask_we    = ($urandom_range(0, 29) == 0);
         mask_wdata = $urandom & 32'h0000_03FF;
         buf_clr    = ($urandom_range(0, 11) == 0);
         clr_bits   = $urandom;
         wait_req   = ($urandom_range(0, 5) == 0);
         wait_clr   = $urandom_range(0, 1) == 1;
         core_busy  = $urandom_range(0, 2) == 0;
         model_step();
         cyc();
         model_compare();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
